pipeline_trace_buffer: RTL and testbench
========================================

# pipeline_trace_buffer

Parametrised on-chip trace capture unit for the pipelined datapath. Each enabled cycle it samples the fetch PC plus NUM_CH watched register values into a circular buffer. It supports free-running wrap capture and PC-triggered one-shot capture. The trace is then streamed out oldest-first over a valid/ready port, so register and PC history can be recovered from silicon or long simulations without per-cycle probing.

## Interface
Parameters:
- DATA_W, 32, width of PC and each channel word
- DEPTH, 16, entries in buffer; power of two, ≥2
- NUM_CH, 4, watched register channels per entry (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst=0 resets on clk edge)
- cap_en  in  1  sample qualifier (pipeline advancing this cycle)
- pc  in  DATA_W  PC to record
- ch_data  in  NUM_CH*DATA_W  watched values; ch k at bits [k*DATA_W +: DATA_W]
- mode  in  1  0 = wrap (continuous), 1 = trigger-then-fill; sampled on arm
- trig_pc  in  DATA_W  trigger PC for mode 1; sampled on arm
- arm  in  1  pulse: clear buffer, start session
- stop  in  1  pulse: end capture
- dump  in  1  pulse: start readout (accepted in DONE only)
- state  out  3  IDLE=0, ARMED=1, CAPTURE=2, DONE=3, READ=4
- count  out  $clog2(DEPTH)+1  valid entries stored
- rd_valid  out  1  readout beat valid
- rd_data  out  DATA_W  readout word
- rd_last  out  1  final beat of readout
- rd_ready  in  1  consumer accepts beat

## Operation
- Reset: state=IDLE, count=0, rd_valid=0, rd_last=0, rd_data=0, pointers 0. Buffer contents are not reset.
- Priority per edge: rst > arm > stop > dump > capture/readout.
- arm in any state: count←0, write ptr←0, latch mode/trig_pc. Next state is CAPTURE for mode 0, ARMED for mode 1. Aborts any readout; rd_valid=0 next cycle.
- ARMED: when cap_en && pc==trig_pc, write that sample as entry 0 and go to CAPTURE. stop → DONE with count=0.
- CAPTURE: each cap_en cycle writes {pc, ch_data} at write ptr; ptr increments mod DEPTH.
  - Mode 1: when the write makes count==DEPTH → DONE. No overwrite.
  - Mode 0: wraps and overwrites oldest; count saturates at DEPTH; runs until stop.
- stop together with cap_en in CAPTURE: sample is written, then DONE.
- stop in IDLE/DONE/READ is ignored. dump outside DONE is ignored.
- DONE: dump → READ. If count==0, dump → IDLE directly with no beats.
- READ: emits count×(NUM_CH+1) beats. Entries go oldest first. Oldest entry is at write ptr if mode 0 wrapped, else entry 0. Within each entry the order is pc, ch0 … ch(NUM_CH−1). rd_last=1 only on the final beat. After the final handshake → IDLE. count holds its value until next arm.
- rd_data=0 whenever rd_valid=0.

## Timing
- Capture latency: sample present at edge T is stored at T; count reflects it after T.
- Trigger match and its write occur on the same edge; state=CAPTURE after it.
- dump accepted at edge T: rd_valid=1 with first beat from T+1.
- Handshake = rd_valid && rd_ready at an edge. The next beat is presented in the following cycle, giving one beat/cycle max.
- While rd_valid && !rd_ready, rd_data and rd_last hold stable.
- No combinational path from rd_ready to rd_data/rd_valid; beat data comes from registered pointers.
- cap_en is ignored in IDLE, DONE and READ; no writes occur.
- rst=0 mid-capture or mid-read: all outputs take reset values after that edge; partial trace is discarded.

## Test plan
- Mode 1, DEPTH=4, NUM_CH=2, trig_pc=0x0C: pc 0x00,0x04,…,0x1C with cap_en=1. Required: state=ARMED until pc=0x0C; entries 0x0C,0x10,0x14,0x18 stored; DONE with count=4. dump yields 12 beats (0x0C,ch0,ch1,0x10,…), rd_last on beat 12, then IDLE.
- Mode 0, DEPTH=4: 6 samples pc 0x00–0x14, then stop. Required: count=4; readout PCs in order 0x08,0x0C,0x10,0x14.
- Backpressure: rd_ready pattern 1,0,0,1,1,… Required: rd_data held stable during stalls; every beat delivered exactly once, in order.
- cap_en gating: mode 0, cap_en=1,0,1,0,1 with pc 0x0,0x4,0x8,0xC,0x10. Required: count=3; PCs 0x0,0x8,0x10.
- arm asserted on beat 3 of a readout. Required: rd_valid=0 next cycle, count=0, state=CAPTURE (mode 0) or ARMED (mode 1).
- rst=0 for one edge mid-CAPTURE. Required: state=IDLE, count=0. Then arm (mode 0), stop immediately, dump: no rd_valid, state returns to IDLE.

Source files
------------

// File: rtl/pipeline_trace_buffer.sv
// On-chip trace capture: records {pc, watched channels} into a circular buffer
// (wrap or PC-triggered one-shot) and streams the trace out oldest-first.
module pipeline_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cap_en,
    input  logic [DATA_W-1:0]          pc,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic                       mode,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       dump,
    output logic [2:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_last,
    input  logic                       rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = NUM_CH + 1;
    localparam int WW = $clog2(NW);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_READ    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_mem [DEPTH][NW];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rd_entry;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_rd_left;
    logic [WW-1:0]     r_rd_word;
    logic              r_mode;
    logic [DATA_W-1:0] r_trig_pc;

    logic w_full;
    logic w_trig_hit;
    logic w_wr;
    logic w_hs;
    logic w_last_beat;
    logic w_dump_go;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_trig_hit  = cap_en && (pc == r_trig_pc);
    assign w_wr        = rst && !arm && cap_en &&
                         ((r_state == S_CAPTURE) ||
                          (r_state == S_ARMED && !stop && w_trig_hit));
    assign w_hs        = (r_state == S_READ) && rd_ready;
    assign w_last_beat = (r_rd_left == CW'(1)) && (r_rd_word == WW'(NUM_CH));
    assign w_dump_go   = !arm && dump && (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (arm) begin
            w_next_state = mode ? S_ARMED : S_CAPTURE;
        end else if (stop && (r_state == S_ARMED || r_state == S_CAPTURE)) begin
            w_next_state = S_DONE;
        end else if (dump && r_state == S_DONE) begin
            w_next_state = (r_count == '0) ? S_IDLE : S_READ;
        end else begin
            case (r_state)
                S_ARMED:   if (w_trig_hit) w_next_state = S_CAPTURE;
                S_CAPTURE: if (cap_en && r_mode && r_count == CW'(DEPTH - 1))
                               w_next_state = S_DONE;
                S_READ:    if (rd_ready && w_last_beat) w_next_state = S_IDLE;
                default:   w_next_state = r_state;
            endcase
        end
    end

    // Bookkeeping: write pointer/count during capture, read cursor during readout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rd_entry <= '0;
            r_rd_word  <= '0;
            r_rd_left  <= '0;
            r_mode     <= 1'b0;
            r_trig_pc  <= '0;
        end else if (arm) begin
            r_count   <= '0;
            r_wptr    <= '0;
            r_mode    <= mode;
            r_trig_pc <= trig_pc;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
                if (!w_full) r_count <= r_count + CW'(1);
            end
            if (w_dump_go) begin
                // A full buffer may have wrapped, so its oldest entry sits at the write pointer.
                r_rd_entry <= w_full ? r_wptr : '0;
                r_rd_word  <= '0;
                r_rd_left  <= r_count;
            end else if (w_hs) begin
                if (r_rd_word == WW'(NUM_CH)) begin
                    r_rd_word  <= '0;
                    r_rd_entry <= r_rd_entry + AW'(1);
                    r_rd_left  <= r_rd_left - CW'(1);
                end else begin
                    r_rd_word <= r_rd_word + WW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr][0] <= pc;
            for (int k = 0; k < NUM_CH; k++) begin
                r_mem[r_wptr][WW'(k + 1)] <= ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state    = r_state;
        count    = r_count;
        rd_valid = (r_state == S_READ);
        rd_last  = rd_valid && w_last_beat;
        rd_data  = rd_valid ? r_mem[r_rd_entry][r_rd_word] : '0;
    end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer (DEPTH=4, NUM_CH=2): constant vector table,
// hand-written corner sequences and random traffic against a queue-based model.
module tb_pipeline_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NCH   = 2;
    localparam int NW    = NCH + 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cap_en = 1'b0;
    logic [DW-1:0]     pc = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic              mode = 1'b0;
    logic [DW-1:0]     trig_pc = '0;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic              dump = 1'b0;
    logic              rd_ready = 1'b0;
    logic [2:0]        state;
    logic [CW-1:0]     count;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              rd_last;

    int checks = 0;
    int failures = 0;

    int                 mState = 0;
    logic               mMode = 1'b0;
    logic [DW-1:0]      mTrig = '0;
    logic [NW*DW-1:0]   mEntries[$];
    logic [DW-1:0]      mBeats[$];

    typedef struct {
        logic          rstN;
        logic          capEn;
        logic [DW-1:0] pcV;
        logic          armV;
        logic          dumpV;
        logic          rdy;
        logic [2:0]    eState;
        logic [CW-1:0] eCount;
        logic          eValid;
        logic [DW-1:0] eData;
        logic          eLast;
    } Vec_t;

    Vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .ch_data(ch_data),
        .mode(mode), .trig_pc(trig_pc), .arm(arm), .stop(stop), .dump(dump),
        .state(state), .count(count), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_ready(rd_ready)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NCH*DW-1:0] chOf(input logic [DW-1:0] p);
        return {p + 32'h200, p + 32'h100};
    endfunction

    function automatic Vec_t mk(input logic r, input logic c, input logic [DW-1:0] p,
                                input logic a, input logic d, input logic y,
                                input logic [2:0] es, input logic [CW-1:0] ec,
                                input logic ev, input logic [DW-1:0] ed, input logic el);
        Vec_t v;
        v.rstN = r; v.capEn = c; v.pcV = p; v.armV = a; v.dumpV = d; v.rdy = y;
        v.eState = es; v.eCount = ec; v.eValid = ev; v.eData = ed; v.eLast = el;
        return v;
    endfunction

    task automatic expectVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of whole entries, trimmed oldest-first when a wrap overflows.
    task automatic pushSample();
        mEntries.push_back({ch_data, pc});
        if (mEntries.size() > DEPTH) void'(mEntries.pop_front());
    endtask

    task automatic modelStep();
        if (!rst) begin
            mState = 0; mEntries.delete(); mBeats.delete();
        end else if (arm) begin
            mEntries.delete(); mBeats.delete();
            mMode = mode; mTrig = trig_pc;
            mState = mode ? 1 : 2;
        end else if (stop && (mState == 1 || mState == 2)) begin
            if (mState == 2 && cap_en) pushSample();
            mState = 3;
        end else if (dump && mState == 3) begin
            if (mEntries.size() == 0) mState = 0;
            else begin
                foreach (mEntries[e])
                    for (int w = 0; w < NW; w++) mBeats.push_back(mEntries[e][w*DW +: DW]);
                mState = 4;
            end
        end else begin
            case (mState)
                1: if (cap_en && pc == mTrig) begin pushSample(); mState = 2; end
                2: if (cap_en) begin
                       pushSample();
                       if (mMode && mEntries.size() == DEPTH) mState = 3;
                   end
                4: if (rd_ready) begin
                       void'(mBeats.pop_front());
                       if (mBeats.size() == 0) mState = 0;
                   end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [DW-1:0] eData;
        eData = (mState == 4) ? mBeats[0] : '0;
        expectVal({tag, ".state"}, 32'(state), 32'(mState));
        expectVal({tag, ".count"}, 32'(count), 32'(mEntries.size()));
        expectVal({tag, ".rd_valid"}, 32'(rd_valid), 32'(mState == 4));
        expectVal({tag, ".rd_data"}, rd_data, eData);
        expectVal({tag, ".rd_last"}, 32'(rd_last), 32'(mState == 4 && mBeats.size() == 1));
    endtask

    task automatic applyStimulus(input logic rstV, input logic capV, input logic [DW-1:0] pcV,
                                 input logic [NCH*DW-1:0] chV, input logic armV, input logic stopV,
                                 input logic dumpV, input logic modeV, input logic [DW-1:0] trigV,
                                 input logic rdyV, input string tag);
        rst = rstV; cap_en = capV; pc = pcV; ch_data = chV; arm = armV; stop = stopV;
        dump = dumpV; mode = modeV; trig_pc = trigV; rd_ready = rdyV;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic cyc(input logic capV, input logic [DW-1:0] pcV, input logic rdyV, input string tag);
        applyStimulus(1'b1, capV, pcV, chOf(pcV), 1'b0, 1'b0, 1'b0, mode, trig_pc, rdyV, tag);
    endtask

    task automatic doArm(input logic modeV, input logic [DW-1:0] trigV, input string tag);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, modeV, trigV, 1'b1, tag);
    endtask

    task automatic doStop(input string tag);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, mode, trig_pc, 1'b0, tag);
    endtask

    task automatic doDump(input string tag);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, mode, trig_pc, 1'b0, tag);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, mode, trig_pc, 1'b0, tag);
    endtask

    // Drains an already-dumped readout, checking the PC of each entry against pcs[].
    task automatic readPcs(input logic [DW-1:0] pcs[$], input string tag);
        int nBeats;
        nBeats = pcs.size() * NW;
        for (int b = 0; b < nBeats; b++) begin
            if (b % NW == 0) expectVal($sformatf("%s.pc%0d", tag, b / NW), rd_data, pcs[b / NW]);
            if (b == nBeats - 1) expectVal({tag, ".last"}, 32'(rd_last), 32'd1);
            cyc(1'b0, '0, 1'b1, tag);
        end
        expectVal({tag, ".idle"}, 32'(state), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] pcList[$];
        logic [DW-1:0] expBeats[$];
        int            delivered;
        logic          rdyPat[$];
        logic          r;

        // Mode 1 trigger at 0x0C, full fill, then complete readout with no stalls.
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 'h000, 0));
        vecs.push_back(mk(1, 0, 'h00, 1, 0, 0, 1, 0, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h00, 0, 0, 0, 1, 0, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h04, 0, 0, 0, 1, 0, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h08, 0, 0, 0, 1, 0, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h0C, 0, 0, 0, 2, 1, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h10, 0, 0, 0, 2, 2, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h14, 0, 0, 0, 2, 3, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h18, 0, 0, 0, 3, 4, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h1C, 0, 0, 0, 3, 4, 0, 'h000, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 1, 1, 4, 4, 1, 'h00C, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h10C, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h20C, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h010, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h110, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h210, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h014, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h114, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h214, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h018, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h118, 0));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 4, 4, 1, 'h218, 1));
        vecs.push_back(mk(1, 0, 'h00, 0, 0, 1, 0, 4, 0, 'h000, 0));
        vecs.push_back(mk(1, 1, 'h20, 0, 0, 0, 0, 4, 0, 'h000, 0));

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].rstN, vecs[i].capEn, vecs[i].pcV, chOf(vecs[i].pcV),
                          vecs[i].armV, 1'b0, vecs[i].dumpV, 1'b1, 32'h0C, vecs[i].rdy, t);
            expectVal({t, ".tState"}, 32'(state), 32'(vecs[i].eState));
            expectVal({t, ".tCount"}, 32'(count), 32'(vecs[i].eCount));
            expectVal({t, ".tValid"}, 32'(rd_valid), 32'(vecs[i].eValid));
            expectVal({t, ".tData"}, rd_data, vecs[i].eData);
            expectVal({t, ".tLast"}, 32'(rd_last), 32'(vecs[i].eLast));
        end

        // Mode 0 wrap: six samples into four entries, oldest two overwritten.
        doReset("wrap");
        doArm(1'b0, '0, "wrap");
        for (int i = 0; i < 6; i++) cyc(1'b1, DW'(4 * i), 1'b0, "wrap");
        doStop("wrap");
        expectVal("wrap.count", 32'(count), 32'd4);
        expectVal("wrap.done", 32'(state), 32'd3);
        doDump("wrap");
        pcList = '{32'h08, 32'h0C, 32'h10, 32'h14};
        readPcs(pcList, "wrap");

        // Backpressure: every beat exactly once, data held while stalled.
        doArm(1'b0, '0, "bp");
        cyc(1'b1, 32'h40, 1'b0, "bp");
        cyc(1'b1, 32'h44, 1'b0, "bp");
        cyc(1'b1, 32'h48, 1'b0, "bp");
        doStop("bp");
        doDump("bp");
        expBeats.delete();
        for (int i = 0; i < 3; i++) begin
            expBeats.push_back(32'h40 + DW'(4 * i));
            expBeats.push_back(32'h140 + DW'(4 * i));
            expBeats.push_back(32'h240 + DW'(4 * i));
        end
        rdyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        delivered = 0;
        for (int k = 0; k < 40 && delivered < 9; k++) begin
            r = rdyPat[k % rdyPat.size()];
            expectVal($sformatf("bp.beat%0d", delivered), rd_data, expBeats[delivered]);
            if (r) delivered++;
            cyc(1'b0, '0, r, "bp");
        end
        expectVal("bp.delivered", 32'(delivered), 32'd9);
        expectVal("bp.idle", 32'(state), 32'd0);

        // cap_en gating in wrap mode.
        doArm(1'b0, '0, "gate");
        cyc(1'b1, 32'h00, 1'b0, "gate");
        cyc(1'b0, 32'h04, 1'b0, "gate");
        cyc(1'b1, 32'h08, 1'b0, "gate");
        cyc(1'b0, 32'h0C, 1'b0, "gate");
        cyc(1'b1, 32'h10, 1'b0, "gate");
        doStop("gate");
        expectVal("gate.count", 32'(count), 32'd3);
        doDump("gate");
        pcList = '{32'h00, 32'h08, 32'h10};
        readPcs(pcList, "gate");

        // arm on the third beat of a readout, once into each mode.
        for (int m = 0; m < 2; m++) begin
            doArm(1'b0, '0, "abort");
            cyc(1'b1, 32'h60, 1'b0, "abort");
            cyc(1'b1, 32'h64, 1'b0, "abort");
            doStop("abort");
            doDump("abort");
            cyc(1'b0, '0, 1'b1, "abort");
            cyc(1'b0, '0, 1'b1, "abort");
            expectVal("abort.beat3", rd_data, 32'h260);
            doArm(m[0], 32'h99, "abort");
            expectVal("abort.valid", 32'(rd_valid), 32'd0);
            expectVal("abort.count", 32'(count), 32'd0);
            expectVal("abort.state", 32'(state), m == 0 ? 32'd2 : 32'd1);
        end

        // Reset mid-capture, then an empty session whose dump goes straight to IDLE.
        doArm(1'b0, '0, "rstmid");
        cyc(1'b1, 32'h50, 1'b0, "rstmid");
        cyc(1'b1, 32'h54, 1'b0, "rstmid");
        doReset("rstmid");
        expectVal("rstmid.state", 32'(state), 32'd0);
        expectVal("rstmid.count", 32'(count), 32'd0);
        doArm(1'b0, '0, "empty");
        doStop("empty");
        expectVal("empty.done", 32'(state), 32'd3);
        doDump("empty");
        expectVal("empty.idle", 32'(state), 32'd0);
        expectVal("empty.valid", 32'(rd_valid), 32'd0);
        cyc(1'b0, '0, 1'b1, "empty");
        expectVal("empty.valid2", 32'(rd_valid), 32'd0);

        // Random traffic against the model.
        doReset("rnd");
        for (int i = 0; i < 2500; i++) begin
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 9) < 7,
                          DW'(4 * $urandom_range(0, 7)),
                          {$urandom, $urandom},
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 5) == 0,
                          1'($urandom_range(0, 1)),
                          DW'(4 * $urandom_range(0, 7)),
                          1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
